// File: rtl/axi4_stream_hdr_pkg.sv
// Shared types and constants for the AXI4-Stream length-header inserter.
package axi4_stream_hdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } hdr_state_e;

  // Header word field layout
  localparam int unsigned LEN_LSB = 0;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned SEQ_LSB = 16;
  localparam int unsigned SEQ_W   = 16;

  localparam logic [LEN_W-1:0] LEN_MAX = 16'hFFFF;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave modports.
interface axi4_stream_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned USER_W = 1,
  parameter int unsigned DEST_W = 1,
  parameter int unsigned ID_W   = 1
);
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  logic [DEST_W-1:0] tdest;
  logic [ID_W-1:0]   tid;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_len_hdr_inserter.sv
// Prepends a one-word length header to each AXI4-Stream packet.
// Define HDR_SEQ_NUM_EN to carry a 16-bit header sequence number in tdata[31:16].
module axi4_stream_len_hdr_inserter
  import axi4_stream_hdr_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH    = 32,
  parameter int unsigned TUSER_WIDTH    = 1,
  parameter int unsigned TDEST_WIDTH    = 1,
  parameter int unsigned TID_WIDTH      = 1,
  parameter int unsigned PKT_SIZE_WIDTH = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PKT_SIZE_WIDTH:0] pkt_size_i,
  axi4_stream_if.slave            pkt_i,
  axi4_stream_if.master           pkt_o,
  output logic [31:0]             pkts_done_o,
  output logic                    busy_o
);

  localparam int unsigned SZ_W = PKT_SIZE_WIDTH + 1;
  localparam logic [TUSER_WIDTH-1:0] HDR_USER = '0;

  hdr_state_e             state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [TDEST_WIDTH-1:0] dest_q, dest_d;
  logic [TID_WIDTH-1:0]   id_q, id_d;
  logic [31:0]            done_q, done_d;
  logic                   busy_q;
  logic [LEN_W-1:0]       len_sat_c;
  logic [TDATA_WIDTH-1:0] hdr_data_c;

  // Clamp the byte count into the 16-bit header field
  if (SZ_W > LEN_W) begin : g_sat
    assign len_sat_c = (pkt_size_i > SZ_W'(LEN_MAX)) ? LEN_MAX : LEN_W'(pkt_size_i);
  end else begin : g_nosat
    assign len_sat_c = LEN_W'(pkt_size_i);
  end

`ifdef HDR_SEQ_NUM_EN
  logic [SEQ_W-1:0] seq_q, seq_d;

  always_comb begin
    seq_d = seq_q;
    if (state_q == ST_HDR && pkt_o.tready) begin
      seq_d = SEQ_W'(seq_q + SEQ_W'(1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  always_comb begin
    hdr_data_c                       = '0;
    hdr_data_c[LEN_LSB +: LEN_W]     = len_q;
    hdr_data_c[SEQ_LSB +: SEQ_W]     = seq_q;
  end
`else
  always_comb begin
    hdr_data_c                       = '0;
    hdr_data_c[LEN_LSB +: LEN_W]     = len_q;
  end
`endif

  // Next-state, header capture and stream muxing
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dest_d  = dest_q;
    id_d    = id_q;
    done_d  = done_q;

    pkt_i.tready = 1'b0;
    pkt_o.tvalid = 1'b0;
    pkt_o.tdata  = '0;
    pkt_o.tkeep  = '0;
    pkt_o.tstrb  = '0;
    pkt_o.tlast  = 1'b0;
    pkt_o.tuser  = HDR_USER;
    pkt_o.tdest  = '0;
    pkt_o.tid    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pkt_i.tvalid) begin
          len_d   = len_sat_c;
          dest_d  = pkt_i.tdest;
          id_d    = pkt_i.tid;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        pkt_o.tvalid = 1'b1;
        pkt_o.tdata  = hdr_data_c;
        pkt_o.tkeep  = '1;
        pkt_o.tstrb  = '1;
        pkt_o.tdest  = dest_q;
        pkt_o.tid    = id_q;
        if (pkt_o.tready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        pkt_o.tvalid = pkt_i.tvalid;
        pkt_o.tdata  = pkt_i.tdata;
        pkt_o.tkeep  = pkt_i.tkeep;
        pkt_o.tstrb  = pkt_i.tstrb;
        pkt_o.tlast  = pkt_i.tlast;
        pkt_o.tuser  = pkt_i.tuser;
        pkt_o.tdest  = pkt_i.tdest;
        pkt_o.tid    = pkt_i.tid;
        pkt_i.tready = pkt_o.tready;
        if (pkt_i.tvalid && pkt_o.tready && pkt_i.tlast) begin
          state_d = ST_IDLE;
          done_d  = done_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      dest_q  <= '0;
      id_q    <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      dest_q  <= dest_d;
      id_q    <= id_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign pkts_done_o = done_q;
  assign busy_o      = busy_q;

endmodule
